// File: rtl/t_preimage_search.sv
// Preimage search engine for the benchmark function t: for a requested
// output pair {po1,po0}, walks all 32 input vectors one per clock and
// reports the lowest matching vector plus the number of matches.
module t_preimage_search #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_target,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_found,
  output logic [4:0] resp_vector,
  output logic [5:0] resp_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] target_reg, target_next;
  logic [4:0] index_reg, index_next;
  logic [4:0] first_reg, first_next;
  logic [5:0] count_reg, count_next;
  logic       found_reg, found_next;

  logic n8, po0, po1, hit;

  // Evaluate t on the vector currently addressed by the scan index.
  always_comb begin
    n8  = index_reg[2] & index_reg[3];
    po0 = (index_reg[1] & ~n8) | (index_reg[0] & index_reg[2]);
    po1 = ~n8 & (index_reg[1] | index_reg[4]);
    hit = ({po1, po0} == target_reg);
  end

  // State and datapath registers; reset discards any in-flight search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      target_reg <= 2'd0;
      index_reg  <= 5'd0;
      first_reg  <= 5'd0;
      count_reg  <= 6'd0;
      found_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      index_reg  <= index_next;
      first_reg  <= first_next;
      count_reg  <= count_next;
      found_reg  <= found_next;
    end
  end

  // Next-state logic: accept in IDLE, scan in SEARCH, hold result in RESP.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    index_next  = index_reg;
    first_next  = first_reg;
    count_next  = count_reg;
    found_next  = found_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          target_next = req_target;
          index_next  = 5'd0;
          first_next  = 5'd0;
          count_next  = 6'd0;
          found_next  = 1'b0;
          state_next  = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          count_next = count_reg + 6'd1;
          if (!found_reg) begin
            found_next = 1'b1;
            first_next = index_reg;
          end
        end
        // Leave on the last vector without wrapping the index.
        if ((index_reg == 5'd31) || (EARLY_EXIT && hit)) begin
          state_next = RESP;
        end else begin
          index_next = index_reg + 5'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs come only from registers; no input-to-output path exists.
  assign req_ready   = (state_reg == IDLE);
  assign resp_valid  = (state_reg == RESP);
  assign resp_found  = found_reg;
  assign resp_vector = first_reg;
  assign resp_count  = count_reg;

endmodule

// File: doc/t_preimage_search.md
# t_preimage_search

Sequential inverse of the two-output combinational benchmark function `t`. Given a requested output pair, the block enumerates all 32 input vectors, one per clock. It reports the first input vector that produces that pair, plus the total number of matching vectors. It sits beside the benchmark netlists as a request/response engine for regression and equivalence stimulus generation.

## Interface
- `EARLY_EXIT`, default 0: 0 = scan all 32 vectors and count every match; 1 = stop at the first match.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request (IDLE only).
- `req_target` input 2: requested outputs; bit1 = po1, bit0 = po0.
- `resp_valid` output 1: result available; held until accepted.
- `resp_ready` input 1: consumer accepts the result.
- `resp_found` output 1: at least one matching vector was found.
- `resp_vector` output 5: first (lowest-index) matching vector, as {pi4,pi3,pi2,pi1,pi0}; 0 if none.
- `resp_count` output 6: number of matching vectors (0..32). Equals 1 on a hit in EARLY_EXIT mode.

## Operation
- Evaluated function, for vector v = {pi4,pi3,pi2,pi1,pi0}:
  - n8 = pi2 & pi3
  - po0 = (pi1 & ~n8) | (pi0 & pi2)
  - po1 = ~n8 & (pi1 | pi4)
  - v matches when {po1,po0} == target.
- FSM states: IDLE, SEARCH, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch `req_target`; clear index, count, found and first vector; go to SEARCH.
- SEARCH:
  - `req_ready` = 0; `req_valid` is ignored.
  - Each cycle evaluates the vector at the current 5-bit index.
  - On a match: count += 1. If found = 0, set found = 1 and record the index as the first vector.
  - Exits to RESP when the index is 31 (after evaluating it), or on the first match if EARLY_EXIT = 1.
  - The index never wraps: vector 31 is evaluated exactly once, then the state leaves SEARCH.
- RESP:
  - `resp_valid` = 1; all resp_* outputs are stable while waiting.
  - On `resp_valid & resp_ready`: go to IDLE.
  - `req_ready` rises on the following cycle; a request in the same cycle as the response handshake is not accepted.
- Count width is 6 bits so that 32 matches is representable. Unused upper values (33..63) never occur.
- Reset, at any time including mid-SEARCH or in RESP:
  - state = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_found` = 0, `resp_vector` = 0, `resp_count` = 0.
  - Any in-flight search is discarded.

## Timing
- Edge E0: request accepted.
- Vector i is evaluated in the cycle after edge E(i) and registered at edge E(i+1).
- Full scan: `resp_valid` is high after edge E32, i.e. a latency of 32 cycles.
- EARLY_EXIT = 1 with a match at vector i: `resp_valid` high after edge E(i+1). No match: 32 cycles.
- Minimum request-to-request spacing: 32 + 1 (response handshake) + 1 (IDLE) cycles for a full scan.
- Outputs are registered only; there is no combinational path from req_* or resp_ready to any output.

## Test plan
- Reset values: assert `rst_n` = 0 -> `req_ready` = 1, `resp_valid` = 0, `resp_found` = 0, `resp_vector` = 0, `resp_count` = 0.
- Full scan, EARLY_EXIT = 0, `resp_ready` held 1:
  - target 00 -> found = 1, vector = 0, count = 9, `resp_valid` 32 cycles after acceptance.
  - target 01 -> vector = 5, count = 5.
  - target 10 -> vector = 16, count = 5.
  - target 11 -> vector = 2, count = 13.
  - The four counts sum to 32.
- Early exit, EARLY_EXIT = 1:
  - target 10 -> vector = 16, count = 1, `resp_valid` 17 cycles after acceptance.
  - target 11 -> vector = 2, `resp_valid` after 3 cycles.
- Backpressure: hold `resp_ready` = 0 for 10 cycles after `resp_valid` -> outputs stable, `req_ready` = 0, and a `req_valid` pulse is ignored. Release -> IDLE one cycle later, then the next request is accepted.
- Request during SEARCH: assert `req_valid` with a different target mid-scan -> not accepted; the result still reflects the original target.
- Reset mid-operation: drop `rst_n` at index 12 of a scan -> immediate IDLE, all outputs at reset values. A new target 01 request then returns vector = 5, count = 5.
